cntr_seq: RTL

- Programmable down-counter sequencer that wraps an N-bit counter register.
- Adds start/stop control, one-shot or periodic (auto-reload) modes, a clock prescaler, a terminal-count strobe and a done flag.
- Sits beside the free-running cntr block and serves as the timing source for blocks that need a counted delay or periodic tick.

---
 rtl/cntr_seq.sv | 139 +++++++++++++
 1 files changed

// File: rtl/cntr_seq.sv
// -----------------------------------------------------------------------------
// cntr_seq -- programmable down-counter sequencer.
//
// Wraps an N-bit down-counter with start/stop control, one-shot or periodic
// (auto-reload) operation, a clock prescaler, a one-cycle terminal-count
// strobe and a sticky done flag. Used as the timing source for blocks that
// need a counted delay or a periodic tick.
//
// Parameters:
//   N      counter width in bits
//   PRESC  clock cycles per count step (>= 1)
//
// Ports:
//   clk       in   system clock, rising edge
//   n_reset   in   asynchronous active-low reset
//   start     in   start / restart a count (level, sampled each edge)
//   stop      in   abort a count, clear done (wins over start)
//   mode      in   0 = one-shot, 1 = periodic; latched on accepted start
//   load_val  in   start value; latched on accepted start
//   Q         out  current count (registered)
//   busy      out  high while counting
//   tc        out  one-cycle terminal-count strobe
//   done      out  high after a one-shot completes, until stop or start
//   err       out  one-cycle strobe: start rejected because load_val == 0
// -----------------------------------------------------------------------------
module cntr_seq #(
  parameter int N     = 4,
  parameter int PRESC = 1
) (
  input  logic         clk,
  input  logic         n_reset,
  input  logic         start,
  input  logic         stop,
  input  logic         mode,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] Q,
  output logic         busy,
  output logic         tc,
  output logic         done,
  output logic         err
);

  // Prescaler is at least one bit wide even when PRESC == 1.
  localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESC - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state,  w_state_nxt;
  logic [N-1:0]  r_q,      w_q_nxt;
  logic [N-1:0]  r_reload, w_reload_nxt;
  logic          r_mode,   w_mode_nxt;
  logic [PW-1:0] r_presc,  w_presc_nxt;
  logic          r_tc,     w_tc_nxt;
  logic          r_err,    w_err_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state  <= IDLE;
      r_q      <= '0;
      r_reload <= '0;
      r_mode   <= 1'b0;
      r_presc  <= '0;
      r_tc     <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_q      <= w_q_nxt;
      r_reload <= w_reload_nxt;
      r_mode   <= w_mode_nxt;
      r_presc  <= w_presc_nxt;
      r_tc     <= w_tc_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next-state logic. Priority: stop, then start, then counting.
  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can
    // leave a value unassigned and infer a latch.
    w_state_nxt  = r_state;
    w_q_nxt      = r_q;
    w_reload_nxt = r_reload;
    w_mode_nxt   = r_mode;
    w_presc_nxt  = r_presc;
    w_tc_nxt     = 1'b0;
    w_err_nxt    = 1'b0;

    if (stop) begin
      // Abort: Q freezes at its current value.
      w_state_nxt = IDLE;
      w_presc_nxt = '0;
    end else if (start) begin
      if (load_val == '0) begin
        // Rejected start consumes the edge: nothing moves, not even the
        // prescaler, so a running count is simply delayed by one cycle.
        w_err_nxt = 1'b1;
      end else begin
        w_state_nxt  = RUN;
        w_q_nxt      = load_val;
        w_reload_nxt = load_val;
        w_mode_nxt   = mode;
        w_presc_nxt  = '0;
      end
    end else if (r_state == RUN) begin
      if (r_presc == PRESC_MAX) begin
        w_presc_nxt = '0;
        if (r_q > N'(1)) begin
          w_q_nxt = r_q - N'(1);
        end else begin
          // Terminal step. Q is never 0 in RUN because a zero load is
          // rejected, so this branch is always the Q == 1 step.
          w_tc_nxt = 1'b1;
          if (r_mode) begin
            w_q_nxt = r_reload;
          end else begin
            w_q_nxt     = '0;
            w_state_nxt = DONE;
          end
        end
      end else begin
        w_presc_nxt = r_presc + PW'(1);
      end
    end
  end

  assign Q    = r_q;
  assign busy = (r_state == RUN);
  assign done = (r_state == DONE);
  assign tc   = r_tc;
  assign err  = r_err;

endmodule
